aes_trace_sequencer: RTL and testbench
======================================

# aes_trace_sequencer

Synthesizable trace-campaign controller that drives the AES_top core through a programmable number of encryptions under one key, replacing hand-timed bench stimulus for power/VCD capture runs. Generates plaintexts in fixed, LFSR-random or interleaved fixed/random (TVLA) mode, holds `AES_en` and data stable per encryption, and raises a trigger for the in-flight window. It returns each ciphertext with its plaintext and index, enforces an idle gap between encryptions, and aborts on a core timeout. It sits between the test/capture infrastructure and AES_top.

## Interface
- `CNT_W`, 16: width of trace count and index.
- `GAP_CYCLES`, 15: idle cycles between encryptions; 0 is treated as 1.
- `TIMEOUT`, 64: maximum cycles in RUN before abort; must be ≥2.

- `AES_clk` in 1: sole clock, rising edge.
- `AES_rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin campaign; sampled in IDLE only.
- `cfg_mode` in 2: 0 fixed, 1 random, 2 interleaved (even index fixed, odd index random), 3 is reserved and behaves as 0.
- `cfg_num` in CNT_W: number of encryptions.
- `cfg_key` in 128: key.
- `cfg_fixed_pt` in 128: fixed plaintext.
- `cfg_seed` in 128: LFSR seed; zero is replaced by 128'h1.
- `core_en` out 1: to `AES_en`.
- `core_data_in` out 128: to `AES_data_in`.
- `core_key_in` out 128: to `AES_key_in`.
- `core_data_out` in 128: from `AES_data_out`.
- `core_data_out_valid` in 1: from `AES_data_out_valid`.
- `trig` out 1: equals `core_en`.
- `busy` out 1: state ≠ IDLE.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out 128: ciphertext.
- `res_pt` out 128: plaintext.
- `res_index` out CNT_W: trace index.
- `res_class` out 1: 0 fixed, 1 random.
- `done` out 1: one-cycle end-of-campaign strobe.
- `timeout_err` out 1: sticky; cleared on the next accepted `start`.

## Operation
- States: IDLE, PREP, RUN, GAP, DONE.
- IDLE + `start`: latch all cfg_* inputs, set idx=0, load LFSR with seed, clear `timeout_err`. Go to DONE if `cfg_num`==0, else to PREP.
- PREP: one cycle.
  - Select the plaintext by mode and idx.
  - Register `core_data_in`, `core_key_in`, `core_en`=1 and `res_class`.
  - Advance the LFSR after a random plaintext is consumed.
  - Go to RUN.
- RUN: `core_en` held at 1; inputs stable; timer counts.
  - On the edge sampling `core_data_out_valid`=1: `core_en`←0, `res_valid`←1, `res_data`←`core_data_out`, `res_pt`←`core_data_in`, `res_index`←idx, idx←idx+1. Go to GAP.
  - When the timer reaches TIMEOUT with no valid: `core_en`←0, `timeout_err`←1, no `res_valid`. Go to DONE.
  - If valid and timeout occur on the same edge, valid wins.
- GAP: wait max(GAP_CYCLES,1) cycles with `core_en`=0, then go to DONE if idx==cfg_num, else to PREP.
- DONE: `done`=1 for one cycle, then go to IDLE.
- LFSR: 128-bit Galois; next = (s<<1) ^ (s[127] ? 128'h87 : 0). The current state is used, then advanced.
- `start` while busy: ignored. `core_data_out_valid` outside RUN: ignored.
- Reset values: all outputs 0, state IDLE. Reset mid-campaign drops `core_en`/`trig` immediately and asynchronously; no `done` is generated.

## Timing
- `start` sampled at edge k → PREP after k. `core_en`/data valid after edge k+1.
- Valid sampled at edge m → `res_valid` and `core_en`=0 after m.
- Next `core_en` rises max(GAP_CYCLES,1)+1 edges after m.
- `done` asserts the cycle after GAP ends (or after the timeout edge); `busy` falls one edge later.
- `core_key_in` is constant for the whole campaign.

## Structure
- Package `aes_trace_pkg` holds:
  - the state enum;
  - mode constants MODE_FIXED/MODE_RANDOM/MODE_TVLA;
  - LFSR_POLY=128'h87;
  - function `lfsr_next`.
- Sub-module `aes_lfsr128`: seed load, advance enable, zero-seed substitution.
- The timer width is $clog2(TIMEOUT+1).

## Test plan
- Fixed mode with the real AES_top: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, cfg_num=3 → three `res_valid` with `res_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `res_index` 0,1,2, then `done`. Check a gap of ≥15 idle `core_en` cycles between encryptions.
- Random mode with a stub core (fixed 10-cycle latency, echoes data), seed=1, cfg_num=4 → `res_pt` = 1, 2, 4, 8. Seed 0 gives the same sequence.
- TVLA mode with fixed_pt=00000083_0…0, seed=80000000_0…0, cfg_num=4 → classes 0,1,0,1. The random plaintexts are 80000000_0…0 and 00…087.
- Stub core that never asserts valid, TIMEOUT=64 → `core_en` is high for exactly 64 cycles, `timeout_err`=1, `done` pulses, no `res_valid`. A later `start` clears `timeout_err`.
- cfg_num=0 → `done` after 1 edge, `core_en` never rises. A second `start` held during RUN has no effect.
- Assert `AES_rst_n`=0 mid-RUN → `core_en`, `trig` and `busy` go to 0 without waiting for a clock edge; no `done`. A restart after reset produces idx from 0.

Source files
------------

// File: rtl/aes_trace_pkg.sv
// Shared types and helpers for the AES trace-campaign sequencer.
package aes_trace_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_RUN  = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [1:0] MODE_FIXED  = 2'd0;
   localparam logic [1:0] MODE_RANDOM = 2'd1;
   localparam logic [1:0] MODE_TVLA   = 2'd2;

   localparam logic [127:0] LFSR_POLY = 128'h87;

   // One step of the 128-bit Galois LFSR (x^128 + x^7 + x^2 + x + 1).
   function automatic logic [127:0] lfsr_next(input logic [127:0] s);
      return {s[126:0], 1'b0} ^ (s[127] ? LFSR_POLY : 128'h0);
   endfunction

endpackage

// File: rtl/aes_trace_sequencer_if.sv
// Bus between the trace sequencer and the AES core.
// Handshake: the sequencer raises core_en with core_data_in/core_key_in and
// holds all three stable until the core returns a one-cycle
// core_data_out_valid with the result on core_data_out; there is no ready,
// the core must accept whenever core_en is high.
interface aes_trace_sequencer_if;
   logic         core_en;
   logic [127:0] core_data_in;
   logic [127:0] core_key_in;
   logic [127:0] core_data_out;
   logic         core_data_out_valid;

   modport master (
      output core_en, core_data_in, core_key_in,
      input  core_data_out, core_data_out_valid
   );

   modport slave (
      input  core_en, core_data_in, core_key_in,
      output core_data_out, core_data_out_valid
   );
endinterface

// File: rtl/aes_lfsr128.sv
// 128-bit Galois LFSR plaintext source with seed load and advance enable.
module aes_lfsr128
   import aes_trace_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [127:0] seed,
   input  logic         adv,
   output logic [127:0] state
);

   logic [127:0] state_d, state_q;

   // Load wins over advance; an all-zero seed would lock up, so use 1 instead.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == '0) ? 128'h1 : seed;
      end else if (adv) begin
         state_d = lfsr_next(state_q);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= '0;
      else        state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/aes_trace_sequencer.sv
// Trace-campaign controller: runs cfg_num encryptions on one key through the
// AES core, generating fixed / random / interleaved plaintexts, and returns
// each ciphertext with its plaintext, index and class.
module aes_trace_sequencer
   import aes_trace_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int GAP_CYCLES = 15,
   parameter int TIMEOUT    = 64
) (
   input  logic                         AES_clk,
   input  logic                         AES_rst_n,
   input  logic                         start,
   input  logic [1:0]                   cfg_mode,
   input  logic [CNT_W-1:0]             cfg_num,
   input  logic [127:0]                 cfg_key,
   input  logic [127:0]                 cfg_fixed_pt,
   input  logic [127:0]                 cfg_seed,
   aes_trace_sequencer_if.master        core,
   output logic                         trig,
   output logic                         busy,
   output logic                         res_valid,
   output logic [127:0]                 res_data,
   output logic [127:0]                 res_pt,
   output logic [CNT_W-1:0]             res_index,
   output logic                         res_class,
   output logic                         done,
   output logic                         timeout_err,
   output state_t                       dbg_state
);

   // A zero gap still needs one idle cycle so core_en visibly drops.
   localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TIMEOUT + 1);
   localparam int GAP_W   = $clog2(GAP_EFF + 1);

   state_t             state_d, state_q;
   logic [1:0]         mode_d, mode_q;
   logic [CNT_W-1:0]   num_d, num_q;
   logic [127:0]       fixed_d, fixed_q;
   logic [127:0]       key_d, key_q;
   logic [127:0]       din_d, din_q;
   logic               en_d, en_q;
   logic               cls_d, cls_q;
   logic [CNT_W-1:0]   idx_d, idx_q;
   logic [TMR_W-1:0]   tmr_d, tmr_q;
   logic [GAP_W-1:0]   gap_d, gap_q;
   logic               terr_d, terr_q;
   logic               rv_d, rv_q;
   logic [127:0]       rdata_d, rdata_q;
   logic [127:0]       rpt_d, rpt_q;
   logic [CNT_W-1:0]   ridx_d, ridx_q;

   logic               lfsr_load, lfsr_adv;
   logic [127:0]       lfsr_state;
   logic               use_rand, timeout_hit, gap_end, core_valid;

   aes_lfsr128 u_lfsr (
      .clk   (AES_clk),
      .rst_n (AES_rst_n),
      .load  (lfsr_load),
      .seed  (cfg_seed),
      .adv   (lfsr_adv),
      .state (lfsr_state)
   );

   // Odd indices are random in interleaved mode; the reserved mode acts as fixed.
   assign use_rand    = (mode_q == MODE_RANDOM) || ((mode_q == MODE_TVLA) && idx_q[0]);
   assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT - 1));
   assign gap_end     = (gap_q == GAP_W'(GAP_EFF - 1));
   assign core_valid  = core.core_data_out_valid;

   // State register; reset drops everything, including core_en, asynchronously.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic; a valid on the timeout edge still counts as a result.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = (cfg_num == '0) ? ST_DONE : ST_PREP;
         ST_PREP: state_d = ST_RUN;
         ST_RUN: begin
            if (core_valid)       state_d = ST_GAP;
            else if (timeout_hit) state_d = ST_DONE;
         end
         ST_GAP:  if (gap_end) state_d = (idx_q == num_q) ? ST_DONE : ST_PREP;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values driven by the current state.
   always_comb begin
      mode_d    = mode_q;
      num_d     = num_q;
      fixed_d   = fixed_q;
      key_d     = key_q;
      din_d     = din_q;
      en_d      = en_q;
      cls_d     = cls_q;
      idx_d     = idx_q;
      tmr_d     = tmr_q;
      gap_d     = gap_q;
      terr_d    = terr_q;
      rv_d      = 1'b0;
      rdata_d   = rdata_q;
      rpt_d     = rpt_q;
      ridx_d    = ridx_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d    = cfg_mode;
               num_d     = cfg_num;
               fixed_d   = cfg_fixed_pt;
               key_d     = cfg_key;
               idx_d     = '0;
               terr_d    = 1'b0;
               lfsr_load = 1'b1;
            end
         end
         ST_PREP: begin
            din_d    = use_rand ? lfsr_state : fixed_q;
            cls_d    = use_rand;
            lfsr_adv = use_rand;
            en_d     = 1'b1;
            tmr_d    = '0;
         end
         ST_RUN: begin
            if (core_valid) begin
               en_d    = 1'b0;
               rv_d    = 1'b1;
               rdata_d = core.core_data_out;
               rpt_d   = din_q;
               ridx_d  = idx_q;
               idx_d   = idx_q + CNT_W'(1);
               gap_d   = '0;
            end else if (timeout_hit) begin
               en_d   = 1'b0;
               terr_d = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_GAP: gap_d = gap_q + GAP_W'(1);
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         mode_q  <= '0;
         num_q   <= '0;
         fixed_q <= '0;
         key_q   <= '0;
         din_q   <= '0;
         en_q    <= 1'b0;
         cls_q   <= 1'b0;
         idx_q   <= '0;
         tmr_q   <= '0;
         gap_q   <= '0;
         terr_q  <= 1'b0;
         rv_q    <= 1'b0;
         rdata_q <= '0;
         rpt_q   <= '0;
         ridx_q  <= '0;
      end else begin
         mode_q  <= mode_d;
         num_q   <= num_d;
         fixed_q <= fixed_d;
         key_q   <= key_d;
         din_q   <= din_d;
         en_q    <= en_d;
         cls_q   <= cls_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         gap_q   <= gap_d;
         terr_q  <= terr_d;
         rv_q    <= rv_d;
         rdata_q <= rdata_d;
         rpt_q   <= rpt_d;
         ridx_q  <= ridx_d;
      end
   end

   assign core.core_en      = en_q;
   assign core.core_data_in = din_q;
   assign core.core_key_in  = key_q;
   assign trig              = en_q;
   assign busy              = (state_q != ST_IDLE);
   assign done              = (state_q == ST_DONE);
   assign res_valid         = rv_q;
   assign res_data          = rdata_q;
   assign res_pt            = rpt_q;
   assign res_index         = ridx_q;
   assign res_class         = cls_q;
   assign timeout_err       = terr_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer with a latency-programmable stub AES core.
module tb_aes_trace_sequencer;
   import aes_trace_pkg::*;

   localparam int CNT_W      = 16;
   localparam int GAP_CYCLES = 15;
   localparam int TIMEOUT    = 64;
   localparam int GAP_EFF    = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
   localparam int NV         = 11;

   typedef struct packed {
      logic             cls;
      logic [CNT_W-1:0] idx;
      logic [127:0]     pt;
      logic [127:0]     data;
   } exp_t;

   typedef struct {
      logic [1:0]         mode;
      int                 num;
      logic [127:0]       fixed;
      logic [127:0]       seed;
      logic [127:0]       key;
      int                 lat;
      int                 exp_res;
      logic               exp_terr;
      logic               mess;
      logic               chk;
      logic [3:0][127:0]  exp_pt;
      logic [3:0]         exp_cls;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic               start;
   logic [1:0]         cfg_mode;
   logic [CNT_W-1:0]   cfg_num;
   logic [127:0]       cfg_key, cfg_fixed_pt, cfg_seed;
   logic               trig, busy, res_valid, res_class, done, timeout_err;
   logic [127:0]       res_data, res_pt;
   logic [CNT_W-1:0]   res_index;
   state_t             dbg_state;

   aes_trace_sequencer_if bus ();

   aes_trace_sequencer #(
      .CNT_W(CNT_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .AES_clk      (clk),
      .AES_rst_n    (rst_n),
      .start        (start),
      .cfg_mode     (cfg_mode),
      .cfg_num      (cfg_num),
      .cfg_key      (cfg_key),
      .cfg_fixed_pt (cfg_fixed_pt),
      .cfg_seed     (cfg_seed),
      .core         (bus),
      .trig         (trig),
      .busy         (busy),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .res_pt       (res_pt),
      .res_index    (res_index),
      .res_class    (res_class),
      .done         (done),
      .timeout_err  (timeout_err),
      .dbg_state    (dbg_state)
   );

   // ---------------- counters / checkers ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // ---------------- stub AES core ----------------
   // Returns data_in ^ key after stub_lat cycles of core_en (0 = never);
   // with stub_spur set it also fires a stray valid three cycles later.
   int           stub_lat = 10;
   logic         stub_spur = 1'b0;
   int           stub_cnt = 0;
   int           post_cnt = 0;
   logic         stub_valid = 1'b0;
   logic [127:0] stub_dout = '0;

   assign bus.core_data_out_valid = stub_valid;
   assign bus.core_data_out       = stub_dout;

   always @(negedge clk) begin
      stub_valid = 1'b0;
      if (!bus.core_en) begin
         stub_cnt = 0;
      end else begin
         stub_cnt++;
         if (stub_lat != 0 && stub_cnt == stub_lat) begin
            stub_valid = 1'b1;
            stub_dout  = bus.core_data_in ^ bus.core_key_in;
            post_cnt   = 1;
         end
      end
      if (!stub_valid && post_cnt != 0) begin
         post_cnt++;
         if (post_cnt == 4) begin
            post_cnt = 0;
            if (stub_spur) begin
               stub_valid = 1'b1;
               stub_dout  = '1;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   exp_t         exp_q[$];
   logic [127:0] seen_pt[$];
   logic         seen_cls[$];

   function automatic logic [127:0] ref_step(input logic [127:0] s);
      return (s << 1) ^ (s[127] ? 128'h87 : 128'h0);
   endfunction

   // Expected results of one campaign: a timeout on the first trace ends it.
   task automatic model_push(input vec_t v, output int n_res, output logic terr);
      logic [127:0] s;
      logic         rnd;
      logic         ok;
      exp_t         e;
      ok    = (v.lat >= 1 && v.lat <= TIMEOUT);
      s     = (v.seed == '0) ? 128'h1 : v.seed;
      n_res = 0;
      terr  = (v.num != 0) && !ok;
      if (ok) begin
         for (int i = 0; i < v.num; i++) begin
            rnd    = (v.mode == 2'd1) || (v.mode == 2'd2 && (i % 2) == 1);
            e.cls  = rnd;
            e.idx  = CNT_W'(i);
            e.pt   = rnd ? s : v.fixed;
            e.data = e.pt ^ v.key;
            if (rnd) s = ref_step(s);
            exp_q.push_back(e);
            n_res++;
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [127:0] cur_key = '0;
   int           exp_hi = 0;
   int           res_cnt = 0;
   int           done_cnt = 0;
   int           hi_run = 0;
   int           lo_run = 0;
   logic         prev_en = 1'b0;
   logic         after_res = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hi_run    = 0;
         lo_run    = 0;
         prev_en   = 1'b0;
         after_res = 1'b0;
      end else begin
         if (bus.core_en) begin
            if (!prev_en && after_res) check_i("gap_idle_cycles", lo_run, GAP_EFF + 1);
            check_v("key_stable", bus.core_key_in, cur_key);
            hi_run++;
            lo_run = 0;
         end else begin
            if (prev_en) check_i("en_high_cycles", hi_run, exp_hi);
            hi_run = 0;
            lo_run++;
         end
         if (res_valid) begin
            res_cnt++;
            after_res = 1'b1;
            seen_pt.push_back(res_pt);
            seen_cls.push_back(res_class);
            check_i("sb_has_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_i("res_index", int'(res_index), int'(e.idx));
               check_v("res_pt", res_pt, e.pt);
               check_v("res_data", res_data, e.data);
               check_b("res_class", res_class, e.cls);
            end
         end
         if (done) begin
            done_cnt++;
            after_res = 1'b0;
         end
         prev_en = bus.core_en;
      end
   end

   // ---------------- driver ----------------
   task automatic run_campaign(input vec_t v, input int exp_res, input logic exp_terr);
      int cyc;
      int res0;
      seen_pt.delete();
      seen_cls.delete();
      cur_key   = v.key;
      stub_lat  = v.lat;
      stub_spur = v.mess;
      exp_hi    = (v.lat >= 1 && v.lat <= TIMEOUT) ? v.lat : TIMEOUT;
      res0      = res_cnt;
      @(negedge clk);
      cfg_mode     = v.mode;
      cfg_num      = CNT_W'(v.num);
      cfg_fixed_pt = v.fixed;
      cfg_seed     = v.seed;
      cfg_key      = v.key;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_b("terr_cleared_on_start", timeout_err, 1'b0);
      if (v.num == 0) begin
         check_b("num0_done", done, 1'b1);
         check_b("num0_en_low", bus.core_en, 1'b0);
         @(negedge clk);
         check_b("num0_busy_fall", busy, 1'b0);
         check_b("num0_done_once", done, 1'b0);
         check_b("num0_en_still_low", bus.core_en, 1'b0);
      end else begin
         check_b("prep_busy", busy, 1'b1);
         check_b("prep_en_low", bus.core_en, 1'b0);
         @(negedge clk);
         check_b("run_en_high", bus.core_en, 1'b1);
         check_b("run_trig_high", trig, 1'b1);
         check_v("run_key", bus.core_key_in, v.key);
         if (v.mess) begin
            start        = 1'b1;
            cfg_mode     = MODE_RANDOM;
            cfg_fixed_pt = ~v.fixed;
            cfg_num      = CNT_W'(7);
            repeat (4) @(negedge clk);
            start = 1'b0;
         end
         cyc = 0;
         while (done !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
         end
         check_b("done_seen", done, 1'b1);
         @(negedge clk);
         check_b("done_one_cycle", done, 1'b0);
         check_b("busy_fall", busy, 1'b0);
         check_i("idle_state", int'(dbg_state), int'(ST_IDLE));
      end
      check_i("res_count", res_cnt - res0, exp_res);
      check_b("timeout_err", timeout_err, exp_terr);
      check_i("sb_leftover", exp_q.size(), 0);
      if (v.chk) begin
         check_i("seq_len", seen_pt.size(), 4);
         for (int j = 0; j < 4 && j < seen_pt.size(); j++) begin
            check_v("pt_sequence", seen_pt[j], v.exp_pt[j]);
            check_b("class_sequence", seen_cls[j], v.exp_cls[j]);
         end
      end
      exp_q.delete();
   endtask

   function automatic vec_t mk(input logic [1:0] mode, input int num,
                               input logic [127:0] fixed, input logic [127:0] seed,
                               input logic [127:0] key, input int lat, input int exp_res,
                               input logic exp_terr, input logic mess);
      vec_t v;
      v.mode = mode;  v.num = num;  v.fixed = fixed;  v.seed = seed;  v.key = key;
      v.lat = lat;    v.exp_res = exp_res;  v.exp_terr = exp_terr;  v.mess = mess;
      v.chk = 1'b0;   v.exp_pt = '0;  v.exp_cls = '0;
      return v;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_reset_values(input string tag);
      check_b({tag, "_core_en"}, bus.core_en, 1'b0);
      check_b({tag, "_trig"}, trig, 1'b0);
      check_b({tag, "_busy"}, busy, 1'b0);
      check_b({tag, "_done"}, done, 1'b0);
      check_b({tag, "_res_valid"}, res_valid, 1'b0);
      check_b({tag, "_timeout_err"}, timeout_err, 1'b0);
      check_v({tag, "_res_data"}, res_data, 128'h0);
      check_v({tag, "_core_key_in"}, bus.core_key_in, 128'h0);
      check_i({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
   endtask

   // ---------------- main sequence ----------------
   vec_t          tbl[NV];
   vec_t          v;
   int            m_res;
   logic          m_terr;
   int            d0;
   int            cyc;
   logic [127:0]  k_nist, p_nist, tv_fixed, tv_seed;

   initial begin
      start = 1'b0;  cfg_mode = '0;  cfg_num = '0;
      cfg_key = '0;  cfg_fixed_pt = '0;  cfg_seed = '0;
      k_nist   = 128'h000102030405060708090a0b0c0d0e0f;
      p_nist   = 128'h00112233445566778899aabbccddeeff;
      tv_fixed = {32'h00000083, 96'h0};
      tv_seed  = {32'h80000000, 96'h0};

      tbl[0]  = mk(MODE_FIXED,  3, p_nist,   128'h0,  k_nist, 10, 3, 1'b0, 1'b0);
      tbl[1]  = mk(MODE_RANDOM, 4, p_nist,   128'h1,  k_nist, 10, 4, 1'b0, 1'b0);
      tbl[1].chk = 1'b1;
      tbl[1].exp_pt = {128'h8, 128'h4, 128'h2, 128'h1};
      tbl[1].exp_cls = 4'b1111;
      tbl[2]  = tbl[1];
      tbl[2].seed = 128'h0;
      tbl[2].lat  = 7;
      tbl[3]  = mk(MODE_TVLA,   4, tv_fixed, tv_seed, k_nist, 12, 4, 1'b0, 1'b0);
      tbl[3].chk = 1'b1;
      tbl[3].exp_pt = {128'h87, tv_fixed, tv_seed, tv_fixed};
      tbl[3].exp_cls = 4'b1010;
      tbl[4]  = mk(MODE_FIXED,  2, p_nist,   128'h0,  k_nist, 0,  0, 1'b1, 1'b0);
      tbl[5]  = mk(MODE_FIXED,  1, p_nist,   128'h0,  k_nist, 64, 1, 1'b0, 1'b0);
      tbl[6]  = mk(MODE_FIXED,  1, p_nist,   128'h0,  k_nist, 65, 0, 1'b1, 1'b0);
      tbl[7]  = mk(2'd3,        2, p_nist,   128'h5,  ~k_nist, 5, 2, 1'b0, 1'b0);
      tbl[8]  = mk(MODE_RANDOM, 0, p_nist,   128'h1,  k_nist, 10, 0, 1'b0, 1'b0);
      tbl[9]  = mk(MODE_FIXED,  1, ~p_nist,  128'h0,  k_nist, 10, 1, 1'b0, 1'b1);
      tbl[10] = mk(MODE_TVLA,   3, p_nist,   128'h3,  k_nist, 1,  3, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check_reset_values("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // table-driven campaigns
      for (int t = 0; t < NV; t++) begin
         model_push(tbl[t], m_res, m_terr);
         run_campaign(tbl[t], tbl[t].exp_res, tbl[t].exp_terr);
      end

      // randomized campaigns against the model
      for (int r = 0; r < 8; r++) begin
         v = mk(2'($urandom_range(0, 3)), $urandom_range(0, 5), rnd128(),
                ($urandom_range(0, 3) == 0) ? 128'h0 : rnd128(), rnd128(),
                ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 25), 0, 1'b0, 1'b0);
         model_push(v, m_res, m_terr);
         run_campaign(v, m_res, m_terr);
      end

      // reset in the middle of RUN
      cur_key  = k_nist;
      stub_lat = 10;
      exp_hi   = 10;
      stub_spur = 1'b0;
      d0 = done_cnt;
      @(negedge clk);
      cfg_mode = MODE_FIXED;  cfg_num = CNT_W'(3);  cfg_fixed_pt = p_nist;
      cfg_key = k_nist;  cfg_seed = 128'h1;  start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (bus.core_en !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check_b("mid_rst_en_rose", bus.core_en, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_b("async_rst_core_en", bus.core_en, 1'b0);
      check_b("async_rst_trig", trig, 1'b0);
      check_b("async_rst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_i("no_done_after_rst", done_cnt - d0, 0);
      check_reset_values("post_rst");
      v = mk(MODE_FIXED, 2, p_nist, 128'h0, k_nist, 6, 2, 1'b0, 1'b0);
      model_push(v, m_res, m_terr);
      run_campaign(v, m_res, m_terr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
